// File: rtl/uart_cmd_bridge.sv
// UART command bridge: 8N1 frames -> addr/data1/data2 + one-cycle trigger, then a readback response frame.
// Optional inter-byte frame timeout is compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_bridge #(
    parameter logic [15:0] BAUD_DIV      = 16'd868,
    parameter logic [15:0] RESP_WAIT     = 16'd256,
    parameter logic [23:0] FRAME_TIMEOUT = 24'd1000000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        uart_rx_in,
    output logic        uart_tx_out,
    output logic        trig_out,
    output logic [15:0] addr_out,
    output logic [15:0] data1_out,
    output logic [15:0] data2_out,
    input  logic [15:0] resp_data_in,
    output logic [7:0]  err_count_out
);

    localparam logic [15:0] HALF_BIT  = BAUD_DIV >> 1;
    localparam logic [15:0] BAUD_LAST = BAUD_DIV - 16'd1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_SYNC, FIELD, CHK, TRIG, WAIT_RESP, TX_ACK, NAK} p_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    rx_state_t   rx_state;
    logic        rx_s1, rx_s2, rx_s3;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic        rx_ferr;

    p_state_t    p_state;
    logic [2:0]  field_idx;
    logic [47:0] hold;
    logic [7:0]  csum;
    logic [15:0] wait_cnt;
    logic        tx_go;
    logic [23:0] tx_go_data;
    logic [1:0]  tx_go_n;
    logic        to_hit;

    logic        tx_active;
    logic [8:0]  tx_frame;
    logic [3:0]  tx_bit;
    logic [15:0] tx_cnt;
    logic [15:0] tx_queue;
    logic [1:0]  tx_left;

    // Receiver: the baud counter restarts on the start edge so every HALF_BIT hit lands mid-bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'h0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h0;
            rx_byte  <= 8'h0;
            rx_done  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1   <= uart_rx_in;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            rx_done <= 1'b0;
            rx_cnt  <= (rx_cnt == BAUD_LAST) ? 16'h0 : rx_cnt + 16'd1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= 16'h0;
                    if (rx_s3 && !rx_s2) rx_state <= RX_START;
                end
                RX_START: if (rx_cnt == HALF_BIT) begin
                    if (rx_s2) rx_state <= RX_IDLE;
                    else begin
                        rx_state <= RX_DATA;
                        rx_bit   <= 3'd0;
                    end
                end
                RX_DATA: if (rx_cnt == HALF_BIT) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_cnt == HALF_BIT) begin
                    rx_done  <= 1'b1;
                    rx_ferr  <= !rx_s2;
                    rx_byte  <= rx_sh;
                    rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    logic [23:0] to_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            to_cnt <= 24'h0;
        end else if (rx_done || !(p_state == FIELD || p_state == CHK)) begin
            to_cnt <= 24'h0;
        end else if (to_cnt != FRAME_TIMEOUT) begin
            to_cnt <= to_cnt + 24'd1;
        end
    end

    assign to_hit = (to_cnt == FRAME_TIMEOUT);
`else
    logic unused_timeout;
    assign unused_timeout = ^FRAME_TIMEOUT;
    assign to_hit = 1'b0;
`endif

    // Parser: the trigger cycle is entered straight from CHK so trig_out follows the stop sample by one edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            p_state       <= WAIT_SYNC;
            field_idx     <= 3'd0;
            hold          <= 48'h0;
            csum          <= 8'h0;
            wait_cnt      <= 16'h0;
            tx_go         <= 1'b0;
            tx_go_data    <= 24'h0;
            tx_go_n       <= 2'd0;
            trig_out      <= 1'b0;
            addr_out      <= 16'h0;
            data1_out     <= 16'h0;
            data2_out     <= 16'h0;
            err_count_out <= 8'h0;
        end else begin
            trig_out <= 1'b0;
            tx_go    <= 1'b0;
            case (p_state)
                WAIT_SYNC: if (rx_done) begin
                    if (rx_ferr) err_count_out <= sat_inc(err_count_out);
                    else if (rx_byte == 8'hA5) begin
                        p_state   <= FIELD;
                        field_idx <= 3'd0;
                        csum      <= 8'h0;
                    end
                end
                FIELD: if (rx_done) begin
                    if (rx_ferr) begin
                        err_count_out <= sat_inc(err_count_out);
                        p_state       <= WAIT_SYNC;
                    end else begin
                        hold      <= {hold[39:0], rx_byte};
                        csum      <= csum ^ rx_byte;
                        field_idx <= field_idx + 3'd1;
                        if (field_idx == 3'd5) p_state <= CHK;
                    end
                end else if (to_hit) begin
                    err_count_out <= sat_inc(err_count_out);
                    p_state       <= WAIT_SYNC;
                end
                CHK: if (rx_done) begin
                    if (rx_ferr) begin
                        err_count_out <= sat_inc(err_count_out);
                        p_state       <= WAIT_SYNC;
                    end else if (rx_byte == csum) begin
                        addr_out  <= hold[47:32];
                        data1_out <= hold[31:16];
                        data2_out <= hold[15:0];
                        trig_out  <= 1'b1;
                        wait_cnt  <= 16'h0;
                        p_state   <= TRIG;
                    end else begin
                        err_count_out <= sat_inc(err_count_out);
                        tx_go         <= 1'b1;
                        tx_go_data    <= {8'hEE, 16'h0};
                        tx_go_n       <= 2'd1;
                        p_state       <= NAK;
                    end
                end else if (to_hit) begin
                    err_count_out <= sat_inc(err_count_out);
                    p_state       <= WAIT_SYNC;
                end
                TRIG: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    p_state  <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (wait_cnt == RESP_WAIT - 16'd1) begin
                        tx_go      <= 1'b1;
                        tx_go_data <= {8'h5A, resp_data_in};
                        tx_go_n    <= 2'd3;
                        p_state    <= TX_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                TX_ACK, NAK: if (!tx_go && !tx_active) p_state <= WAIT_SYNC;
                default: p_state <= WAIT_SYNC;
            endcase
        end
    end

    // Transmitter: the next queued byte is loaded on the last stop-bit cycle, so bytes run back to back.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            uart_tx_out <= 1'b1;
            tx_active   <= 1'b0;
            tx_frame    <= 9'h1FF;
            tx_bit      <= 4'd0;
            tx_cnt      <= 16'h0;
            tx_queue    <= 16'h0;
            tx_left     <= 2'd0;
        end else if (tx_go && !tx_active) begin
            tx_active   <= 1'b1;
            tx_frame    <= {1'b1, tx_go_data[23:16]};
            uart_tx_out <= 1'b0;
            tx_queue    <= tx_go_data[15:0];
            tx_left     <= tx_go_n - 2'd1;
            tx_bit      <= 4'd0;
            tx_cnt      <= 16'h0;
        end else if (tx_active) begin
            if (tx_cnt == BAUD_LAST) begin
                tx_cnt <= 16'h0;
                if (tx_bit == 4'd9) begin
                    if (tx_left != 2'd0) begin
                        tx_frame    <= {1'b1, tx_queue[15:8]};
                        tx_queue    <= {tx_queue[7:0], 8'h0};
                        tx_left     <= tx_left - 2'd1;
                        uart_tx_out <= 1'b0;
                        tx_bit      <= 4'd0;
                    end else begin
                        tx_active   <= 1'b0;
                        uart_tx_out <= 1'b1;
                    end
                end else begin
                    uart_tx_out <= tx_frame[0];
                    tx_frame    <= {1'b1, tx_frame[8:1]};
                    tx_bit      <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: command frames in, trigger and response frames checked.
module tb_uart_cmd_bridge;

    localparam int          BD = 16;
    localparam int          RW = 40;
    localparam logic [23:0] FT = 24'd3000;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        uart_rx_in = 1'b1;
    logic [15:0] resp_data_in = 16'h0;
    logic        uart_tx_out;
    logic        trig_out;
    logic [15:0] addr_out, data1_out, data2_out;
    logic [7:0]  err_count_out;

    uart_cmd_bridge #(
        .BAUD_DIV(16'(BD)), .RESP_WAIT(16'(RW)), .FRAME_TIMEOUT(FT)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .uart_rx_in(uart_rx_in),
        .uart_tx_out(uart_tx_out), .trig_out(trig_out), .addr_out(addr_out),
        .data1_out(data1_out), .data2_out(data2_out),
        .resp_data_in(resp_data_in), .err_count_out(err_count_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int trig_cnt = 0;
    int trig_cyc = 0;
    logic [15:0] cap_addr = 16'h0, cap_d1 = 16'h0, cap_d2 = 16'h0;
    logic [7:0]  txq[$];
    int          txc[$];

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial forever begin
        @(negedge clk_in);
        if (trig_out === 1'b1) begin
            trig_cnt++;
            trig_cyc = cyc;
            cap_addr = addr_out;
            cap_d1   = data1_out;
            cap_d2   = data2_out;
        end
    end

    // Serial decoder for the response line; records each byte and the cycle its start bit began.
    initial begin
        logic       prev;
        logic [7:0] b;
        int         st;
        prev = 1'b1;
        b = 8'h0;
        forever begin
            @(negedge clk_in);
            if (prev === 1'b1 && uart_tx_out === 1'b0) begin
                st = cyc;
                repeat (BD / 2) @(negedge clk_in);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk_in);
                    b[i] = uart_tx_out;
                end
                repeat (BD) @(negedge clk_in);
                txq.push_back(b);
                txc.push_back(st);
            end
            prev = uart_tx_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk_in);
        uart_rx_in = 1'b0;
        repeat (BD) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            repeat (BD) @(negedge clk_in);
        end
        uart_rx_in = stop;
        repeat (BD) @(negedge clk_in);
        uart_rx_in = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int t;
        t = 0;
        while (txq.size() < n && t < 20000) begin
            @(negedge clk_in);
            t++;
        end
        chk(tag, 32'(txq.size() >= n), 32'd1);
        repeat (2 * BD) @(negedge clk_in);
    endtask

    task automatic clear_tx();
        txq.delete();
        txc.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_tx", 32'(uart_tx_out), 32'd1);
        chk("rst_trig", 32'(trig_out), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'h0);
        chk("rst_d1", 32'(data1_out), 32'h0);
        chk("rst_d2", 32'(data2_out), 32'h0);
        chk("rst_err", 32'(err_count_out), 32'h0);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);

        // GET
        resp_data_in = 16'hBEEF;
        send_frame(64'hA5_00_00_00_01_00_00_01);
        wait_tx(3, "get_tx_cnt");
        chk("get_trig", 32'(trig_cnt), 32'd1);
        chk("get_addr", 32'(cap_addr), 32'h0000);
        chk("get_d1", 32'(cap_d1), 32'h0001);
        chk("get_d2", 32'(cap_d2), 32'h0000);
        chk("get_b0", 32'(txq[0]), 32'h5A);
        chk("get_b1", 32'(txq[1]), 32'hBE);
        chk("get_b2", 32'(txq[2]), 32'hEF);
        chk("get_lat", 32'(txc[0] - trig_cyc), 32'(RW + 1));
        chk("get_b2b", 32'(txc[1] - txc[0]), 32'(10 * BD));
        clear_tx();

        // SET
        resp_data_in = 16'h1357;
        send_frame(64'hA5_01_00_00_02_12_34_25);
        wait_tx(3, "set_tx_cnt");
        chk("set_trig", 32'(trig_cnt), 32'd2);
        chk("set_addr", 32'(cap_addr), 32'h0100);
        chk("set_d1", 32'(cap_d1), 32'h0002);
        chk("set_d2", 32'(cap_d2), 32'h1234);
        chk("set_hold", 32'(addr_out), 32'h0100);
        chk("set_b0", 32'(txq[0]), 32'h5A);
        chk("set_b1", 32'(txq[1]), 32'h13);
        chk("set_b2", 32'(txq[2]), 32'h57);
        chk("set_err", 32'(err_count_out), 32'h0);
        clear_tx();

        // Bad checksum
        send_frame(64'hA5_01_00_00_02_12_34_26);
        wait_tx(1, "bad_tx_cnt");
        chk("bad_trig", 32'(trig_cnt), 32'd2);
        chk("bad_nak", 32'(txq[0]), 32'hEE);
        chk("bad_nbytes", 32'(txq.size()), 32'd1);
        chk("bad_addr", 32'(addr_out), 32'h0100);
        chk("bad_d1", 32'(data1_out), 32'h0002);
        chk("bad_d2", 32'(data2_out), 32'h1234);
        chk("bad_err", 32'(err_count_out), 32'h01);
        clear_tx();

        // Framing error on third byte, then a clean frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (4 * BD) @(negedge clk_in);
        chk("fe_err", 32'(err_count_out), 32'h02);
        chk("fe_trig", 32'(trig_cnt), 32'd2);
        chk("fe_notx", 32'(txq.size()), 32'd0);
        resp_data_in = 16'hCAFE;
        send_frame(64'hA5_00_02_AB_CD_00_01_65);
        wait_tx(3, "fe2_tx_cnt");
        chk("fe2_trig", 32'(trig_cnt), 32'd3);
        chk("fe2_addr", 32'(cap_addr), 32'h0002);
        chk("fe2_d1", 32'(cap_d1), 32'hABCD);
        chk("fe2_d2", 32'(cap_d2), 32'h0001);
        chk("fe2_b0", 32'(txq[0]), 32'h5A);
        chk("fe2_b1", 32'(txq[1]), 32'hCA);
        chk("fe2_b2", 32'(txq[2]), 32'hFE);
        clear_tx();

        // Reset in the middle of a frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("mr_tx", 32'(uart_tx_out), 32'd1);
        chk("mr_trig", 32'(trig_out), 32'd0);
        chk("mr_addr", 32'(addr_out), 32'h0);
        chk("mr_d1", 32'(data1_out), 32'h0);
        chk("mr_d2", 32'(data2_out), 32'h0);
        chk("mr_err", 32'(err_count_out), 32'h0);
        chk("mr_notrig", 32'(trig_cnt), 32'd3);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        send_frame(64'hA5_01_00_00_02_12_34_25);
        wait_tx(3, "mr2_tx_cnt");
        chk("mr2_trig", 32'(trig_cnt), 32'd4);
        chk("mr2_addr", 32'(addr_out), 32'h0100);
        chk("mr2_d2", 32'(data2_out), 32'h1234);
        clear_tx();

`ifdef UART_CMD_TIMEOUT_EN
        // Partial frame abandoned by the inter-byte timeout
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (int'(FT) + 10) @(negedge clk_in);
        chk("to_err", 32'(err_count_out), 32'h01);
        chk("to_notx", 32'(txq.size()), 32'd0);
        chk("to_notrig", 32'(trig_cnt), 32'd4);
        send_frame(64'hA5_00_02_AB_CD_00_01_65);
        wait_tx(3, "to2_tx_cnt");
        chk("to2_trig", 32'(trig_cnt), 32'd5);
        chk("to2_d1", 32'(data1_out), 32'hABCD);
        clear_tx();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
